// File: rtl/led_pkg.sv
// Shared state encoding and LED drive levels for the blink arbiter.
// Pure declarations: no latency, no flow control.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LED_ON  = 2'd1,
    LED_OFF = 2'd2
  } state_t;

  localparam logic LED_LIT  = 1'b1;
  localparam logic LED_DARK = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts at last_grant+1 and wraps modulo NREQ.
// Zero latency; a winner is offered whenever any request is high, with no backpressure.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last_grant,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = int'(last_grant) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_blink_arbiter.sv
// Grants the LED round-robin to one requester for count x (dur+1 on, dur+1 off), registered outputs.
// One IDLE cycle between sessions; LED_BLINK_ARBITER_ABORT_EN ends a session early when the owner drops req.
module led_blink_arbiter
  import led_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMER_W = 26,
  parameter int CNT_W   = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*TIMER_W-1:0] req_dur,
  input  logic [NREQ*CNT_W-1:0]   req_count,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    MY_LED
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  state_t             state, state_nxt;
  logic [NREQ-1:0]    grant_nxt, done_nxt;
  logic               busy_nxt, led_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt, dur_q, dur_nxt;
  logic [CNT_W-1:0]   remaining, rem_nxt;
  logic [IDXW-1:0]    last_grant, last_nxt;

  logic [NREQ-1:0]    win;
  logic               win_vld;
  logic [IDXW-1:0]    win_idx;
  logic [TIMER_W-1:0] win_dur;
  logic [CNT_W-1:0]   win_cnt;
  logic               abort;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .winner     (win),
    .valid      (win_vld)
  );

  always_comb begin
    win_idx = '0;
    win_dur = '0;
    win_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        win_idx = IDXW'(i);
        win_dur = req_dur[i*TIMER_W +: TIMER_W];
        win_cnt = req_count[i*CNT_W +: CNT_W];
      end
    end
  end

`ifdef LED_BLINK_ARBITER_ABORT_EN
  assign abort = ~|(req & grant);
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    done_nxt  = '0;
    busy_nxt  = busy;
    led_nxt   = MY_LED;
    timer_nxt = timer;
    dur_nxt   = dur_q;
    rem_nxt   = remaining;
    last_nxt  = last_grant;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = LED_ON;
          grant_nxt = win;
          busy_nxt  = 1'b1;
          led_nxt   = LED_LIT;
          timer_nxt = win_dur;
          dur_nxt   = win_dur;
          rem_nxt   = (win_cnt == '0) ? CNT_ONE : win_cnt;
          last_nxt  = win_idx;
        end
      end
      LED_ON, LED_OFF: begin
        if (abort) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          led_nxt   = LED_DARK;
          timer_nxt = '0;
          rem_nxt   = '0;
        end else if (timer != '0) begin
          timer_nxt = timer - TIMER_ONE;
        end else if (state == LED_ON) begin
          state_nxt = LED_OFF;
          led_nxt   = LED_DARK;
          timer_nxt = dur_q;
        end else if (remaining == CNT_ONE) begin
          // Last off phase done: hand the LED back and tell the owner.
          state_nxt = IDLE;
          grant_nxt = '0;
          done_nxt  = grant;
          busy_nxt  = 1'b0;
          rem_nxt   = '0;
        end else begin
          state_nxt = LED_ON;
          led_nxt   = LED_LIT;
          timer_nxt = dur_q;
          rem_nxt   = remaining - CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      MY_LED     <= LED_DARK;
      timer      <= '0;
      dur_q      <= '0;
      remaining  <= '0;
      last_grant <= IDXW'(NREQ - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      done       <= done_nxt;
      busy       <= busy_nxt;
      MY_LED     <= led_nxt;
      timer      <= timer_nxt;
      dur_q      <= dur_nxt;
      remaining  <= rem_nxt;
      last_grant <= last_nxt;
    end
  end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed bench: per-cycle expected outputs are queued with each stimulus and popped at negedge.
// Covers reset, single blinker, round-robin, count zero, max count, reset mid-session and abort.
module tb_led_blink_arbiter;

  localparam int NREQ = 4;
  localparam int TW   = 26;
  localparam int CW   = 4;

  logic                 CLOCK_50 = 1'b0;
  logic                 RESET_N;
  logic [NREQ-1:0]      req;
  logic [NREQ*TW-1:0]   req_dur;
  logic [NREQ*CW-1:0]   req_count;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic                 busy;
  logic                 MY_LED;

  always #5 CLOCK_50 = ~CLOCK_50;

  led_blink_arbiter #(.NREQ(NREQ), .TIMER_W(TW), .CNT_W(CW)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .req       (req),
    .req_dur   (req_dur),
    .req_count (req_count),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .MY_LED    (MY_LED)
  );

  typedef struct {
    logic [3:0] g;
    logic [3:0] d;
    logic       b;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
    n_chk++;
    assert (obs === ex) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [3:0] d, input logic b, input logic l);
    exp_t e;
    e.g = g;
    e.d = d;
    e.b = b;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic run_check(input string tag);
    exp_t e;
    int   c;
    c = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge CLOCK_50);
      chk($sformatf("%s c%0d grant", tag, c), 32'(grant),  32'(e.g));
      chk($sformatf("%s c%0d done",  tag, c), 32'(done),   32'(e.d));
      chk($sformatf("%s c%0d busy",  tag, c), 32'(busy),   32'(e.b));
      chk($sformatf("%s c%0d led",   tag, c), 32'(MY_LED), 32'(e.l));
      c++;
    end
  endtask

  // Hold reset, load stimulus, release just after an edge; first sampled cycle is the arbitration cycle.
  task automatic start(input logic [3:0] r, input int dur, input int cnt);
    RESET_N = 1'b0;
    req     = '0;
    @(posedge CLOCK_50);
    #1;
    req_dur   = '0;
    req_count = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r[i]) begin
        req_dur[i*TW +: TW]   = TW'(dur);
        req_count[i*CW +: CW] = CW'(cnt);
      end
    end
    req     = r;
    RESET_N = 1'b1;
    push(4'b0000, 4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    RESET_N   = 1'b0;
    req       = '0;
    req_dur   = '0;
    req_count = '0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("reset grant", 32'(grant),  32'd0);
    chk("reset done",  32'(done),   32'd0);
    chk("reset busy",  32'(busy),   32'd0);
    chk("reset led",   32'(MY_LED), 32'd0);

    // Single requester, dur=2 count=2, then re-grant since req stays high.
    start(4'b0001, 2, 2);
    for (int k = 0; k < 12; k++)
      push(4'b0001, 4'b0000, 1'b1, ((k % 6) < 3) ? 1'b1 : 1'b0);
    push(4'b0000, 4'b0001, 1'b0, 1'b0);
    push(4'b0001, 4'b0000, 1'b1, 1'b1);
    run_check("single");

    // Reset in LED_ON: outputs clear asynchronously.
    #1 RESET_N = 1'b0;
    #1;
    chk("midreset grant", 32'(grant),  32'd0);
    chk("midreset done",  32'(done),   32'd0);
    chk("midreset busy",  32'(busy),   32'd0);
    chk("midreset led",   32'(MY_LED), 32'd0);

    // Round-robin from requester 0 after reset.
    start(4'b1111, 0, 1);
    for (int k = 0; k < 5; k++) begin
      push(4'(1 << (k % 4)), 4'b0000, 1'b1, 1'b1);
      push(4'(1 << (k % 4)), 4'b0000, 1'b1, 1'b0);
      push(4'b0000, 4'(1 << (k % 4)), 1'b0, 1'b0);
    end
    run_check("rr");

    // Count zero behaves as a single blink.
    start(4'b0100, 1, 0);
    push(4'b0100, 4'b0000, 1'b1, 1'b1);
    push(4'b0100, 4'b0000, 1'b1, 1'b1);
    push(4'b0100, 4'b0000, 1'b1, 1'b0);
    push(4'b0100, 4'b0000, 1'b1, 1'b0);
    push(4'b0000, 4'b0100, 1'b0, 1'b0);
    run_check("cnt0");

    // Maximum count, 1-cycle phases.
    start(4'b1000, 0, 15);
    for (int k = 0; k < 15; k++) begin
      push(4'b1000, 4'b0000, 1'b1, 1'b1);
      push(4'b1000, 4'b0000, 1'b1, 1'b0);
    end
    push(4'b0000, 4'b1000, 1'b0, 1'b0);
    run_check("cntmax");

    // Owner drops req in its second blink.
    start(4'b0010, 1, 3);
    push(4'b0010, 4'b0000, 1'b1, 1'b1);
    push(4'b0010, 4'b0000, 1'b1, 1'b1);
    push(4'b0010, 4'b0000, 1'b1, 1'b0);
    push(4'b0010, 4'b0000, 1'b1, 1'b0);
    push(4'b0010, 4'b0000, 1'b1, 1'b1);
    run_check("drop pre");
    #1 req = 4'b0000;
`ifdef LED_BLINK_ARBITER_ABORT_EN
    push(4'b0000, 4'b0000, 1'b0, 1'b0);
    push(4'b0000, 4'b0000, 1'b0, 1'b0);
`else
    push(4'b0010, 4'b0000, 1'b1, 1'b1);
    push(4'b0010, 4'b0000, 1'b1, 1'b0);
    push(4'b0010, 4'b0000, 1'b1, 1'b0);
    push(4'b0010, 4'b0000, 1'b1, 1'b1);
    push(4'b0010, 4'b0000, 1'b1, 1'b1);
    push(4'b0010, 4'b0000, 1'b1, 1'b0);
    push(4'b0010, 4'b0000, 1'b1, 1'b0);
    push(4'b0000, 4'b0010, 1'b0, 1'b0);
    push(4'b0000, 4'b0000, 1'b0, 1'b0);
`endif
    run_check("drop post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/led_blink_arbiter.md
LED_BLINK_ARBITER -- requirements
Module: led_blink_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMER_W, default 26, phase-timer width.
REQ-003 SHALL have parameter CNT_W, default 4, blink-count width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: CLOCK_50  input  1  50 MHz clock.
REQ-005 SHALL have RESET_N  input  1  asynchronous active-low reset.
REQ-006 SHALL have req  input  NREQ  per-requester blink request, level.
REQ-007 SHALL have req_dur  input  NREQ*TIMER_W  per-requester phase duration; slice i = [i*TIMER_W +: TIMER_W].
REQ-008 SHALL have req_count  input  NREQ*CNT_W  per-requester blink count; slice i = [i*CNT_W +: CNT_W].
REQ-009 SHALL have grant  output  NREQ  one-hot owner of the LED, registered.
REQ-010 SHALL have done  output  NREQ  one-cycle completion pulse to the owner, registered.
REQ-011 SHALL have busy  output  1  high while a session is active.
REQ-012 SHALL have MY_LED  output  1  LED drive, registered, 1 = lit.

Function
REQ-013 SHALL implement FSM states IDLE, LED_ON and LED_OFF.
REQ-014 SHALL, in IDLE with any req high, pick the requester round-robin starting at last_grant+1 mod NREQ, then move to LED_ON on the next edge.
REQ-015 SHALL, on that edge, latch the winner's dur and count, set its grant bit, set busy=1, MY_LED=1 and timer=dur.
REQ-016 SHALL make each phase last dur+1 cycles; dur=0 gives 1-cycle phases.
REQ-017 SHALL decrement the timer in LED_ON/LED_OFF; at timer==0, reload dur and toggle phase (LED_ON to LED_OFF sets MY_LED=0; LED_OFF to LED_ON sets MY_LED=1).
REQ-018 SHALL treat latched count==0 as 1; one blink = one LED_ON phase plus one LED_OFF phase.
REQ-019 SHALL, at the end of LED_OFF with remaining==1, go to IDLE, clear grant and busy, and pulse done[owner] for exactly one cycle.
REQ-020 SHALL, at the end of LED_OFF with remaining>1, decrement remaining and return to LED_ON.
REQ-021 SHALL sample req and its dur/count only in IDLE; changes during a session have no effect, except as stated in REQ-027.
REQ-022 SHALL spend at least one IDLE cycle between sessions, with grant==0 and MY_LED==0 in that cycle.
REQ-023 SHALL update last_grant at the grant edge; a requester that holds req high continuously SHALL lose to any other waiting requester.

Reset
REQ-024 SHALL, while RESET_N=0, force state=IDLE, grant=0, done=0, busy=0, MY_LED=0, timer=0, remaining=0 and last_grant=NREQ-1 (requester 0 first).
REQ-025 SHALL abandon any in-flight session on reset without a done pulse; the first arbitration SHALL occur on the first edge after RESET_N rises.

Configuration
REQ-026 SHALL be controlled by the macro LED_BLINK_ARBITER_ABORT_EN.
REQ-027 SHALL, with the macro defined, abort the session when req[owner] falls during LED_ON/LED_OFF: the next edge goes to IDLE with MY_LED=0, grant=0, busy=0, and no done pulse.
REQ-028 SHALL, without the macro, ignore req deassertion during a session and always complete it with done.

Structure
REQ-029 SHALL place state_t (IDLE, LED_ON, LED_OFF) and the LED ON/OFF constants in the shared package led_pkg.
REQ-030 SHALL implement the combinational round-robin pick in sub-module rr_arbiter, parameterised by NREQ, with inputs req and last_grant, and outputs a one-hot winner and a valid flag.

Verification
REQ-031 SHALL cover the single-requester case: req[0]=1, dur=2, count=2 -> MY_LED pattern 1,1,1,0,0,0,1,1,1,0,0,0; then done[0] for one cycle; grant[0] high for 12 cycles.
REQ-032 SHALL cover round-robin fairness: req=4'b1111 held, dur=0, count=1 -> grants in order 0,1,2,3,0, each session 2 cycles plus 1 IDLE cycle.
REQ-033 SHALL cover count zero: count=0, dur=1 -> exactly one blink (2 on, 2 off), then done.
REQ-034 SHALL cover reset mid-session: RESET_N=0 during LED_ON -> MY_LED, grant and busy go to 0 immediately with no done; after release, requester 0 wins first.
REQ-035 SHALL cover abort: with LED_BLINK_ARBITER_ABORT_EN, drop req[1] in its second blink -> IDLE next cycle, MY_LED=0, done=0; without the macro the session completes with done[1].
REQ-036 SHALL cover the maximum count: count=15, dur=0 -> 15 on/off pairs (30 cycles), and done fires exactly once.
